trap_ctrl: RTL
==============

# trap_ctrl

Interrupt/return sequencer for the pipelined core. Arbitrates external interrupt requests, chooses the cycle a trap is taken, and captures SEPC from the EX-stage PC. Drives the INT/eret/SEPC inputs of the next-PC logic and flushes IF/ID/EX on trap entry and return. Holds the global interrupt enable and per-source mask, written by the CSR path.

## Interface
- `NUM_IRQ`, default 4: number of interrupt sources, range 2..8.
- `TRAP_VEC`, default 32'h1c09_0000: handler entry address. Exported for reference only; next-PC logic applies it when `int_o` is high.
- `clk` in 1: core clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `irq_req` in NUM_IRQ: level-sensitive interrupt requests.
- `irq_ack` out NUM_IRQ: one-hot, one-cycle pulse on the source being serviced.
- `ex_valid` in 1: EX stage holds a real (non-bubble) instruction.
- `ex_pc` in 32: PC of the EX-stage instruction.
- `stall` in 1: hazard stall; the pipeline does not advance this cycle.
- `eret_dec` in 1: EX instruction is eret; qualified by `ex_valid`.
- `csr_we` in 1: write enable for the enable/mask register.
- `csr_wdata` in NUM_IRQ+1: bit 0 = `ie`, bits NUM_IRQ:1 = mask.
- `int_o` out 1: take trap now; connects to next-PC INT.
- `eret_o` out 1: return now; connects to next-PC eret.
- `sepc` out 32: saved exception PC.
- `cause` out 8: index of the last serviced source, zero-extended.
- `flush` out 1: squash IF/ID/EX.
- `in_handler` out 1: high while in HANDLER state.
- `ie_o` out 1: current global interrupt enable.

## Operation
- State machine states: IDLE, PEND, HANDLER.
- Eligible set: `irq_req & mask`. A source can win only when `ie`=1.
- **IDLE:** if the eligible set is non-empty and `ie`=1, latch the winner index, then go to PEND.
- **PEND:** `take` = `ex_valid & !stall & !eret_dec`.
  - On `take`: `int_o`=1, `flush`=1, and the winner's `irq_ack` bit pulses.
  - At the following edge: `sepc`<=`ex_pc`, `cause`<=winner, `ie`<=0 with the previous `ie` saved in `pie`; go to HANDLER.
  - The EX instruction is squashed and re-executes on return.
  - The latched winner is kept even if `irq_req` drops while in PEND.
- **HANDLER:** requests are ignored (no nesting).
  - On `eret_dec & ex_valid & !stall`: `eret_o`=1, `flush`=1.
  - At the edge: `ie`<=`pie`; go to IDLE.
- **eret outside HANDLER:** `eret_o`=1 and `flush`=1 using the current `sepc`. No state change. In PEND this cycle is not a `take` cycle.
- **CSR write:** `csr_we` updates `ie` and mask at the edge.
  - In PEND, if the written `ie`=0, go to IDLE without acknowledging the source.
  - In HANDLER, writing `ie` writes `pie`. The live `ie` stays 0.
  - If the CSR write and the `take` condition coincide, the trap is taken first. The write then lands in `pie`.
- `int_o` and `eret_o` are never high together.

## Timing
- Reset values: state IDLE, `ie`=0, `pie`=0, mask all ones, `sepc`=0, `cause`=0, arbitration pointer 0.
- All outputs are 0 at reset except `sepc` and `cause`, which are 0 by value.
- `int_o`, `eret_o`, `flush` and `irq_ack` are combinational from state plus `ex_valid`/`stall`/`eret_dec`.
- No combinational path from `irq_req` to any output.
- Latency: request sampled at edge N → PEND in cycle N+1 → `int_o` no earlier than cycle N+1. Each `stall` cycle or bubble in EX adds one cycle.
- `sepc`, `cause`, `ie`, `in_handler` change only at the edge after the event.
- The handler-entry cycle cannot also be an eret cycle.
- Reset asserted mid-trap returns to IDLE immediately. Any in-flight `int_o` or `flush` drops asynchronously.

## Configuration
- Macro `TRAP_RR_EN`.
  - **Defined:** round-robin arbitration. The search starts at the pointer; after each acknowledgement the pointer becomes winner+1 modulo NUM_IRQ.
  - **Undefined:** fixed priority, lowest index wins. No pointer register is built.

## Test plan
- Reset, CSR write `ie`=1 with mask=4'b1111, raise `irq_req`=4'b0100 with `ex_pc`=32'h1c000010, no stall → `int_o`, `flush`, `irq_ack`=4'b0100 all high one cycle later; then `sepc`=32'h1c000010, `cause`=2, `in_handler`=1, `ie_o`=0.
- In HANDLER, raise `irq_req`=4'b0001 → no `irq_ack`. Then `eret_dec` with `ex_valid` → `eret_o`=1, `flush`=1, `ie_o`=1 next cycle; after that, source 0 is acknowledged.
- `irq_req`=4'b1010 with `ie`=1 → source 1 wins in both builds. Hold both requests across two traps: source 3 wins second with `TRAP_RR_EN`; source 1 wins again without it.
- In PEND, hold `stall`=1 for 3 cycles, then drop `irq_req` and release `stall` → `int_o` fires on the first unstalled cycle; `sepc` equals `ex_pc` from that cycle.
- In PEND, CSR write `ie`=0 → returns to IDLE, no `int_o`, no `irq_ack`. Also: mask=0 with `irq_req` high → never enters PEND.
- Assert `rstn`=0 during the `int_o` cycle → all outputs 0 immediately; after release, `ie_o`=0 and state IDLE.

Source files
------------

// File: rtl/trap_ctrl.sv
// Interrupt/return sequencer: arbitrates IRQs, times trap entry/eret, keeps ie/pie/mask.
// Optional `TRAP_RR_EN selects round-robin arbitration instead of fixed lowest-index priority.
module trap_ctrl #(
    parameter int          NUM_IRQ  = 4,
    parameter logic [31:0] TRAP_VEC = 32'h1c09_0000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_IRQ-1:0] irq_req,
    output logic [NUM_IRQ-1:0] irq_ack,
    input  logic               ex_valid,
    input  logic [31:0]        ex_pc,
    input  logic               stall,
    input  logic               eret_dec,
    input  logic               csr_we,
    input  logic [NUM_IRQ:0]   csr_wdata,
    output logic               int_o,
    output logic               eret_o,
    output logic [31:0]        sepc,
    output logic [7:0]         cause,
    output logic               flush,
    output logic               in_handler,
    output logic               ie_o
);

    localparam int IW = $clog2(NUM_IRQ);

    if (NUM_IRQ < 2 || NUM_IRQ > 8 || TRAP_VEC[1:0] != 2'b00) begin : g_bad_cfg
        $error("trap_ctrl: NUM_IRQ out of range or TRAP_VEC misaligned");
    end

    typedef enum logic [1:0] {IDLE, PEND, HANDLER} state_t;

    state_t             state;
    logic               ie;
    logic               pie;
    logic [NUM_IRQ-1:0] mask;
    logic [IW-1:0]      win;
    logic [IW-1:0]      win_nxt;
    logic [IW-1:0]      idx;
    logic               found;
    logic [NUM_IRQ-1:0] elig;
    logic               go;
    logic               take;
    logic               ret;

`ifdef TRAP_RR_EN
    logic [IW-1:0]      ptr;
`endif

    assign elig = irq_req & mask;

    always_comb begin
        win_nxt = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
`ifdef TRAP_RR_EN
            idx = IW'((int'(ptr) + k) % NUM_IRQ);
`else
            idx = IW'(k);
`endif
            if (!found && elig[idx]) begin
                found   = 1'b1;
                win_nxt = idx;
            end
        end
    end

    // Reset gates the strobes so they drop asynchronously with rstn.
    assign go   = rstn & ex_valid & ~stall;
    assign take = (state == PEND) & go & ~eret_dec;
    assign ret  = go & eret_dec;

    assign int_o      = take;
    assign eret_o     = ret;
    assign flush      = take | ret;
    assign irq_ack    = take ? (NUM_IRQ'(1) << win) : '0;
    assign in_handler = (state == HANDLER);
    assign ie_o       = ie;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            ie    <= 1'b0;
            pie   <= 1'b0;
            mask  <= '1;
            sepc  <= '0;
            cause <= '0;
            win   <= '0;
`ifdef TRAP_RR_EN
            ptr   <= '0;
`endif
        end else begin
            if (csr_we) mask <= csr_wdata[NUM_IRQ:1];
            unique case (state)
                IDLE: begin
                    if (csr_we) ie <= csr_wdata[0];
                    if (ie && found) begin
                        win   <= win_nxt;
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (take) begin
                        state <= HANDLER;
                        sepc  <= ex_pc;
                        cause <= 8'(win);
                        ie    <= 1'b0;
                        // a coinciding CSR write lands in pie
                        pie   <= csr_we ? csr_wdata[0] : ie;
`ifdef TRAP_RR_EN
                        ptr   <= (win == IW'(NUM_IRQ - 1)) ? '0 : win + 1'b1;
`endif
                    end else if (csr_we) begin
                        ie <= csr_wdata[0];
                        if (!csr_wdata[0]) state <= IDLE;
                    end
                end
                HANDLER: begin
                    if (csr_we) pie <= csr_wdata[0];
                    if (ret) begin
                        state <= IDLE;
                        ie    <= csr_we ? csr_wdata[0] : pie;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
